// File: rtl/sccb_apb_seq.sv
// APB-programmed SCCB master: write-command FIFO plus register-read sequencer driving SIOC/SIOD.
// Optional interrupt-enable register and irq output are built when SCCB_APB_SEQ_IRQ_EN is defined.
module sccb_apb_seq #(
    parameter int CLK_FREQ   = 10_000_000,
    parameter int SCCB_FREQ  = 100_000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        PCLK,
    input  logic        PRESETN,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [7:0]  PADDR,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        sioc,
    output logic        siod_oe,
    input  logic        siod_i,
    output logic        cam_pwdn,
    output logic        cam_rstn,
    output logic        irq
);

    localparam int DIV = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int AW  = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, START, BYTE, STOP, RSTART} state_t;

    state_t          state_q, state_d;
    logic [1:0]      qtr_q, qtr_d, phase_q, phase_d;
    logic [3:0]      bit_q, bit_d;
    logic            rd_txn_q, rd_txn_d, rd_step_q, rd_step_d;
    logic [CW-1:0]   div_q, div_d;
    logic [15:0]     cmd_q, cmd_d;
    logic [7:0]      rx_q, rx_d;
    logic            sioc_q, sioc_d, siod_oe_q, siod_oe_d;

    logic            enable_q, enable_d, pwdn_q, pwdn_d, rstn_q, rstn_d;
    logic [6:0]      id_q, id_d;
    logic [7:0]      raddr_q, raddr_d, rdata_q, rdata_d;
    logic            done_q, done_d, ovf_q, ovf_d, rd_pend_q, rd_pend_d;

    logic [15:0]     mem_q [FIFO_DEPTH];
    logic [15:0]     mem_d [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;

    logic            wr_en, push_req, push, pop, fifo_clr, full, empty, busy;
    logic            tick, last_phase, rd_phase, txn_done, rd_done;
    logic [7:0]      tx_byte_d;
    logic            rd_phase_d;
    logic [2:0]      bit_idx_d;
    logic            unused_pwdata;

`ifdef SCCB_APB_SEQ_IRQ_EN
    logic [1:0]      irq_en_q, irq_en_d;
    logic            irq_q, irq_d;
`endif

    function automatic logic [7:0] phase_byte(input logic [1:0] ph, input logic rd_txn,
                                              input logic rd_step, input logic [15:0] cmd,
                                              input logic [6:0] id, input logic [7:0] raddr);
        if (ph == 2'd0)      return {id, rd_step};
        else if (ph == 2'd1) return rd_txn ? raddr : cmd[15:8];
        else                 return cmd[7:0];
    endfunction

    assign wr_en         = PSEL & PENABLE & PWRITE;
    assign full          = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty         = (count_q == '0);
    assign busy          = (state_q != IDLE);
    assign push_req      = wr_en && (PADDR == 8'h0C);
    assign push          = push_req && !full;
    assign fifo_clr      = wr_en && (PADDR == 8'h00) && PWDATA[1];
    assign PSLVERR       = push_req && full;
    assign PREADY        = 1'b1;
    assign tick          = (div_q == CW'(DIV - 1));
    assign last_phase    = rd_txn_q ? (phase_q == 2'd1) : (phase_q == 2'd2);
    assign rd_phase      = rd_step_q && (phase_q == 2'd1);
    assign sioc          = sioc_q;
    assign siod_oe       = siod_oe_q;
    assign cam_pwdn      = pwdn_q;
    assign cam_rstn      = rstn_q;
    assign unused_pwdata = ^PWDATA[31:16];

    // Transaction engine; the quarter divider only runs while a transaction is on the bus.
    always_comb begin
        state_d   = state_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        phase_d   = phase_q;
        rd_txn_d  = rd_txn_q;
        rd_step_d = rd_step_q;
        cmd_d     = cmd_q;
        rx_d      = rx_q;
        pop       = 1'b0;
        txn_done  = 1'b0;
        rd_done   = 1'b0;
        div_d     = (state_q == IDLE || tick) ? '0 : div_q + CW'(1);
        case (state_q)
            IDLE: begin
                if (enable_q && (rd_pend_q || !empty)) begin
                    state_d   = START;
                    qtr_d     = 2'd0;
                    bit_d     = 4'd0;
                    phase_d   = 2'd0;
                    rd_step_d = 1'b0;
                    rd_txn_d  = rd_pend_q;
                    if (!rd_pend_q) begin
                        pop   = 1'b1;
                        cmd_d = mem_q[rd_ptr_q];
                    end
                end
            end
            START, RSTART: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        state_d = (state_q == START) ? BYTE : START;
                        bit_d   = 4'd0;
                    end
                end
            end
            BYTE: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd2 && rd_phase && bit_q < 4'd8)
                        rx_d = {rx_q[6:0], siod_i};
                    if (qtr_q == 2'd3) begin
                        bit_d = bit_q + 4'd1;
                        if (bit_q == 4'd8) begin
                            bit_d   = 4'd0;
                            phase_d = phase_q + 2'd1;
                            if (last_phase)
                                state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    qtr_d = qtr_q + 2'd1;
                    if (qtr_q == 2'd3) begin
                        phase_d = 2'd0;
                        if (rd_txn_q && !rd_step_q) begin
                            state_d   = RSTART;
                            rd_step_d = 1'b1;
                        end else begin
                            state_d  = IDLE;
                            txn_done = 1'b1;
                            rd_done  = rd_txn_q;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin levels are decoded from the next engine state so they register alongside it.
    always_comb begin
        tx_byte_d  = phase_byte(phase_d, rd_txn_d, rd_step_d, cmd_d, id_q, raddr_q);
        rd_phase_d = rd_step_d && (phase_d == 2'd1);
        bit_idx_d  = 3'(4'd7 - bit_d);
        sioc_d     = 1'b1;
        siod_oe_d  = 1'b0;
        case (state_d)
            START: begin
                sioc_d    = (qtr_d < 2'd2);
                siod_oe_d = (qtr_d != 2'd0);
            end
            BYTE: begin
                sioc_d    = (qtr_d == 2'd1) || (qtr_d == 2'd2);
                siod_oe_d = !rd_phase_d && (bit_d < 4'd8) && !tx_byte_d[bit_idx_d];
            end
            STOP: begin
                sioc_d    = (qtr_d != 2'd0);
                siod_oe_d = (qtr_d < 2'd2);
            end
            default: begin
                sioc_d    = 1'b1;
                siod_oe_d = 1'b0;
            end
        endcase
    end

    // Register file; set events are applied after W1C clears so they win.
    always_comb begin
        enable_d  = enable_q;
        pwdn_d    = pwdn_q;
        rstn_d    = rstn_q;
        id_d      = id_q;
        raddr_d   = raddr_q;
        rdata_d   = rd_done ? rx_q : rdata_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
        rd_pend_d = rd_done ? 1'b0 : rd_pend_q;
        if (wr_en) begin
            case (PADDR)
                8'h00: begin
                    enable_d = PWDATA[0];
                    pwdn_d   = PWDATA[3];
                    rstn_d   = PWDATA[4];
                    if (PWDATA[2]) rd_pend_d = 1'b1;
                end
                8'h04: begin
                    if (PWDATA[3]) done_d = 1'b0;
                    if (PWDATA[4]) ovf_d  = 1'b0;
                end
                8'h08:   id_d    = PWDATA[6:0];
                8'h10:   raddr_d = PWDATA[7:0];
                default: ;
            endcase
        end
        if (txn_done)         done_d = 1'b1;
        if (push_req && full) ovf_d  = 1'b1;
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
        if (push)
            mem_d[wr_ptr_q] = PWDATA[15:0];
        if (fifo_clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

`ifdef SCCB_APB_SEQ_IRQ_EN
    always_comb begin
        irq_en_d = (wr_en && PADDR == 8'h1C) ? PWDATA[1:0] : irq_en_q;
        irq_d    = |(irq_en_d & {ovf_d, done_d});
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    always_comb begin
        PRDATA = '0;
        case (PADDR)
            8'h00: PRDATA = {27'd0, rstn_q, pwdn_q, 2'b00, enable_q};
            8'h04: PRDATA = {26'd0, rd_pend_q, ovf_q, done_q, full, empty, busy};
            8'h08: PRDATA = {25'd0, id_q};
            8'h10: PRDATA = {24'd0, raddr_q};
            8'h14: PRDATA = {24'd0, rdata_q};
            8'h18: PRDATA = 32'(count_q);
`ifdef SCCB_APB_SEQ_IRQ_EN
            8'h1C: PRDATA = {30'd0, irq_en_q};
`endif
            default: PRDATA = '0;
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q   <= IDLE;
            qtr_q     <= '0;
            bit_q     <= '0;
            phase_q   <= '0;
            rd_txn_q  <= 1'b0;
            rd_step_q <= 1'b0;
            div_q     <= '0;
            cmd_q     <= '0;
            rx_q      <= '0;
            sioc_q    <= 1'b1;
            siod_oe_q <= 1'b0;
            enable_q  <= 1'b0;
            pwdn_q    <= 1'b0;
            rstn_q    <= 1'b1;
            id_q      <= 7'h21;
            raddr_q   <= '0;
            rdata_q   <= '0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            rd_pend_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
`ifdef SCCB_APB_SEQ_IRQ_EN
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            phase_q   <= phase_d;
            rd_txn_q  <= rd_txn_d;
            rd_step_q <= rd_step_d;
            div_q     <= div_d;
            cmd_q     <= cmd_d;
            rx_q      <= rx_d;
            sioc_q    <= sioc_d;
            siod_oe_q <= siod_oe_d;
            enable_q  <= enable_d;
            pwdn_q    <= pwdn_d;
            rstn_q    <= rstn_d;
            id_q      <= id_d;
            raddr_q   <= raddr_d;
            rdata_q   <= rdata_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            rd_pend_q <= rd_pend_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
`ifdef SCCB_APB_SEQ_IRQ_EN
            irq_en_q  <= irq_en_d;
            irq_q     <= irq_d;
`endif
        end
    end

endmodule

// File: tb/tb_sccb_apb_seq.sv
// Directed bench for sccb_apb_seq: a bus monitor decodes START/STOP/bytes off SIOC/SIOD and
// checks them against a queue of expected tokens; a small device model answers reads.
module tb_sccb_apb_seq;

    localparam int TOK_START = 256;
    localparam int TOK_STOP  = 257;
`ifdef SCCB_APB_SEQ_IRQ_EN
    localparam logic [31:0] IRQ_EXP    = 32'd1;
    localparam logic [31:0] IRQEN_MASK = 32'h3;
`else
    localparam logic [31:0] IRQ_EXP    = 32'd0;
    localparam logic [31:0] IRQEN_MASK = 32'h0;
`endif

    logic        PCLK = 1'b0;
    logic        PRESETN = 1'b0;
    logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = '0;
    logic [31:0] PWDATA = '0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic        sioc, siod_oe, siod_i;
    logic        cam_pwdn, cam_rstn, irq;

    logic        dev_low = 1'b0;
    logic        siod_line;
    int          tests = 0;
    int          fails = 0;
    int          exp_q[$];
    int          last_period = 0;

    sccb_apb_seq dut (
        .PCLK(PCLK), .PRESETN(PRESETN), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .sioc(sioc), .siod_oe(siod_oe), .siod_i(siod_i),
        .cam_pwdn(cam_pwdn), .cam_rstn(cam_rstn), .irq(irq)
    );

    // Open-drain SIOD: pulled up unless the master or the device model pulls it low.
    assign siod_line = !siod_oe && !dev_low;
    assign siod_i    = siod_line;

    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_check(input int tok);
        int e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected", tok, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("sb_token", tok, e);
        end
    endtask

    task automatic push_txn(input logic [7:0] addr_byte, input logic [15:0] cmd);
        exp_q.push_back(TOK_START);
        exp_q.push_back(addr_byte);
        exp_q.push_back(cmd[15:8]);
        exp_q.push_back(cmd[7:0]);
        exp_q.push_back(TOK_STOP);
    endtask

    // Bus monitor and read-device model, sampling on the falling PCLK edge.
    initial begin : monitor
        logic       prev_sioc, prev_siod, rd_mode;
        logic [7:0] shreg;
        logic [7:0] rd_val;
        int         bitcnt, cyc, last_rise;
        prev_sioc = 1'b1; prev_siod = 1'b1; rd_mode = 1'b0;
        shreg = '0; rd_val = 8'h76; bitcnt = 0; cyc = 0; last_rise = 0;
        forever begin
            @(negedge PCLK);
            cyc++;
            if (!PRESETN) begin
                bitcnt  = 0;
                rd_mode = 1'b0;
                dev_low = 1'b0;
            end else begin
                if (prev_sioc && sioc && prev_siod && !siod_line) begin
                    bitcnt = 0;
                    sb_check(TOK_START);
                end else if (prev_sioc && sioc && !prev_siod && siod_line) begin
                    bitcnt  = 0;
                    rd_mode = 1'b0;
                    sb_check(TOK_STOP);
                end
                if (!prev_sioc && sioc) begin
                    if (bitcnt > 0 && bitcnt < 9) last_period = cyc - last_rise;
                    last_rise = cyc;
                    if (bitcnt < 8) shreg = {shreg[6:0], siod_line};
                    bitcnt++;
                    if (bitcnt == 9) begin
                        check("ninth_bit_released", {31'd0, siod_line}, 32'd1);
                        sb_check({24'd0, shreg});
                        rd_mode = rd_mode ? 1'b0 : (shreg == 8'h43);
                        bitcnt  = 0;
                    end
                end
                if (prev_sioc && !sioc)
                    dev_low = rd_mode && (bitcnt < 8) && !rd_val[3'(7 - bitcnt)];
            end
            prev_sioc = sioc;
            prev_siod = siod_line;
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [7:0] addr, input logic [31:0] data, output logic err);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic wr(input logic [7:0] addr, input logic [31:0] data);
        logic err;
        applyStimulus(addr, data, err);
    endtask

    task automatic rd(input logic [7:0] addr, output logic [31:0] data);
        @(negedge PCLK);
        PSEL = 1'b1; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
        @(negedge PCLK);
        PENABLE = 1'b1;
        #1 data = PRDATA;
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic checkOutput(input logic [7:0] addr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        rd(addr, d);
        check(tag, d, exp);
    endtask

    task automatic wait_status(input logic [31:0] mask, input logic [31:0] val, input string tag);
        logic [31:0] st;
        st = '0;
        for (int i = 0; i < 1000; i++) begin
            rd(8'h04, st);
            if ((st & mask) == val) break;
            repeat (20) @(negedge PCLK);
        end
        check(tag, st & mask, val);
    endtask

    initial begin : stimulus
        logic err;
        logic [15:0] cmds [5];
        cmds = '{16'h1122, 16'h3344, 16'h5566, 16'h7788, 16'h99AA};

        // Reset state
        repeat (5) @(negedge PCLK);
        #1;
        check("rst_sioc", {31'd0, sioc}, 32'd1);
        check("rst_siod_oe", {31'd0, siod_oe}, 32'd0);
        PRESETN = 1'b1;
        check("rst_cam_pwdn", {31'd0, cam_pwdn}, 32'd0);
        check("rst_cam_rstn", {31'd0, cam_rstn}, 32'd1);
        check("rst_pready", {31'd0, PREADY}, 32'd1);
        checkOutput(8'h00, 32'h10, "rst_ctrl");
        checkOutput(8'h04, 32'h02, "rst_status");
        checkOutput(8'h08, 32'h21, "rst_id");
        checkOutput(8'h18, 32'h0, "rst_level");
        checkOutput(8'h20, 32'h0, "unmapped_read");

        // Single write transaction with the default ID
        wr(8'h1C, 32'h1);
        checkOutput(8'h1C, 32'h1 & IRQEN_MASK, "irq_en_rb");
        applyStimulus(8'h0C, 32'h1280, err);
        check("cmd_slverr", {31'd0, err}, 32'd0);
        checkOutput(8'h18, 32'd1, "level_one");
        push_txn(8'h42, 16'h1280);
        wr(8'h00, 32'h11);
        wait_status(32'h0B, 32'h0A, "single_done");
        check("single_sb_empty", exp_q.size(), 32'd0);
        check("sioc_period", last_period, 32'd100);
        check("irq_after_done", {31'd0, irq}, IRQ_EXP);
        wr(8'h04, 32'h08);
        check("irq_after_w1c", {31'd0, irq}, 32'd0);
        checkOutput(8'h04, 32'h02, "status_after_w1c");

        // Five queued commands run back to back in FIFO order
        wr(8'h00, 32'h10);
        foreach (cmds[i]) begin
            wr(8'h0C, {16'd0, cmds[i]});
            push_txn(8'h42, cmds[i]);
        end
        checkOutput(8'h18, 32'd5, "level_five");
        wr(8'h00, 32'h11);
        checkOutput(8'h18, 32'd4, "level_after_pop");
        wait_status(32'h0B, 32'h0A, "five_done");
        checkOutput(8'h18, 32'd0, "level_zero");
        check("five_sb_empty", exp_q.size(), 32'd0);

        // Overflow with the engine disabled; the FIFO pointers wrap here
        wr(8'h04, 32'h08);
        wr(8'h00, 32'h10);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(8'h0C, 32'h0100 + i, err);
            check("fill_slverr", {31'd0, err}, 32'd0);
        end
        applyStimulus(8'h0C, 32'hDEAD, err);
        check("ovf_slverr", {31'd0, err}, 32'd1);
        checkOutput(8'h04, 32'h14, "ovf_status");
        checkOutput(8'h18, 32'd8, "ovf_level");
        applyStimulus(8'h10, 32'h0A, err);
        check("raddr_slverr", {31'd0, err}, 32'd0);
        wr(8'h04, 32'h10);
        checkOutput(8'h04, 32'h04, "ovf_w1c");
        wr(8'h00, 32'h12);
        checkOutput(8'h18, 32'd0, "clr_level");
        checkOutput(8'h00, 32'h10, "ctrl_selfclear");

        // A pending read beats a queued write
        wr(8'h0C, 32'h3355);
        wr(8'h00, 32'h14);
        checkOutput(8'h04, 32'h20, "rd_pend_set");
        checkOutput(8'h10, 32'h0A, "raddr_rb");
        exp_q.push_back(TOK_START); exp_q.push_back(8'h42); exp_q.push_back(8'h0A);
        exp_q.push_back(TOK_STOP);
        exp_q.push_back(TOK_START); exp_q.push_back(8'h43); exp_q.push_back(8'h76);
        exp_q.push_back(TOK_STOP);
        push_txn(8'h42, 16'h3355);
        wr(8'h00, 32'h11);
        wait_status(32'h2B, 32'h0A, "read_done");
        checkOutput(8'h14, 32'h76, "rdata");
        check("read_sb_empty", exp_q.size(), 32'd0);

        // Camera pins, ID and IRQ_EN
        wr(8'h00, 32'h08);
        #1;
        check("cam_pwdn_set", {31'd0, cam_pwdn}, 32'd1);
        check("cam_rstn_clr", {31'd0, cam_rstn}, 32'd0);
        checkOutput(8'h00, 32'h08, "ctrl_pins");
        wr(8'h08, 32'hF5);
        checkOutput(8'h08, 32'h75, "id_write");
        wr(8'h1C, 32'h3);
        checkOutput(8'h1C, 32'h3 & IRQEN_MASK, "irq_en_both");
        check("irq_pre_reset", {31'd0, irq}, IRQ_EXP);

        // Asynchronous reset in the middle of the second phase
        wr(8'h0C, 32'h1280);
        exp_q.push_back(TOK_START);
        exp_q.push_back(8'hEA);
        wr(8'h00, 32'h09);
        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge PCLK);
        check("rst_first_byte_seen", exp_q.size(), 32'd0);
        for (int i = 0; i < 500 && !(sioc == 1'b0 && siod_oe == 1'b1); i++) @(negedge PCLK);
        check("rst_pre_bus_low", {30'd0, sioc, siod_oe}, 32'b01);
        #3 PRESETN = 1'b0;
        #1;
        check("rst_mid_sioc", {31'd0, sioc}, 32'd1);
        check("rst_mid_siod_oe", {31'd0, siod_oe}, 32'd0);
        check("rst_mid_irq", {31'd0, irq}, 32'd0);
        check("rst_mid_cam", {30'd0, cam_pwdn, cam_rstn}, 32'b01);
        repeat (3) @(negedge PCLK);
        PRESETN = 1'b1;
        checkOutput(8'h00, 32'h10, "rst2_ctrl");
        checkOutput(8'h04, 32'h02, "rst2_status");
        checkOutput(8'h08, 32'h21, "rst2_id");
        checkOutput(8'h18, 32'd0, "rst2_level");
        checkOutput(8'h14, 32'd0, "rst2_rdata");
        checkOutput(8'h10, 32'd0, "rst2_raddr");
        checkOutput(8'h1C, 32'd0, "rst2_irq_en");
        repeat (300) @(negedge PCLK);
        check("rst2_bus_idle", {30'd0, sioc, siod_oe}, 32'b10);

        // Dropping ENABLE mid-transaction finishes the current one only
        wr(8'h0C, 32'hAA01);
        wr(8'h0C, 32'hBB02);
        push_txn(8'h42, 16'hAA01);
        wr(8'h00, 32'h11);
        wr(8'h00, 32'h10);
        wait_status(32'h09, 32'h08, "disable_done");
        checkOutput(8'h18, 32'd1, "disable_level");
        repeat (300) @(negedge PCLK);
        checkOutput(8'h04, 32'h08, "disable_holds_idle");
        check("final_sb_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
